// File: rtl/sysu_freq_meter.sv
// Gate-window frequency meter: counts synchronized rising edges of sig_in
// over GATE_CYCLES clocks, then converts the count to BCD with a serial
// double-dabble before publishing freq/bcd/ovf with a one-cycle valid.
//
// Handshake: valid is a single-cycle pulse with no back-pressure; freq, bcd
// and ovf change only in the cycle valid is high and hold otherwise.
module sysu_freq_meter #(
    parameter int CLK_HZ      = 50000000,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = 32,
    parameter int BCD_DIGITS  = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sig_in,
    output logic [CNT_W-1:0]        freq,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    ovf,
    output logic                    valid,
    output logic                    gate
);

    // Window counter width, conversion step counter width.
    localparam int WW = $clog2(GATE_CYCLES);
    localparam int CW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    // Enough internal digits to hold any CNT_W-bit value, and at least
    // BCD_DIGITS so the output slice always exists.
    localparam int DIG_NEED = (CNT_W * 3 + 9) / 10 + 1;
    localparam int DIG_INT  = (DIG_NEED > BCD_DIGITS) ? DIG_NEED : BCD_DIGITS;
    // Comparison width wide enough for 10^10-1 and for the count itself.
    localparam int LW = (CNT_W > 34) ? CNT_W : 34;

    typedef enum logic [1:0] {
        ST_GATE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // One double-dabble step: add 3 to every digit >= 5, then shift in bit_in.
    function automatic logic [4*DIG_INT-1:0] dd_step(
        input logic [4*DIG_INT-1:0] cur,
        input logic                 bit_in
    );
        logic [4*DIG_INT-1:0] adj;
        adj = cur;
        for (int i = 0; i < DIG_INT; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj[4*DIG_INT-2:0], bit_in};
    endfunction

    // Largest value representable on the bcd output: 10^BCD_DIGITS - 1.
    function automatic logic [LW-1:0] dec_limit();
        logic [LW-1:0] v;
        v = LW'(1);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            v = v * LW'(10);
        end
        return v - LW'(1);
    endfunction

    localparam logic [LW-1:0] LIMIT = dec_limit();

    state_t                 state;
    state_t                 state_next;
    logic                   s1, s2, s3;
    logic [WW-1:0]          win_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       conv_val;
    logic [CNT_W-1:0]       bin_sh;
    logic [4*DIG_INT-1:0]   bcd_sh;
    logic [CW-1:0]          conv_cnt;

    logic                   edge_det;
    logic                   win_last;
    logic                   conv_last;
    logic [CNT_W-1:0]       edge_sum;
    logic [4*DIG_INT-1:0]   bcd_next;
    logic                   over;

    assign edge_det  = s2 & ~s3;
    assign win_last  = (win_cnt == WW'(GATE_CYCLES - 1));
    assign conv_last = (conv_cnt == CW'(CNT_W - 1));
    // Saturating increment: a full counter ignores further edges.
    assign edge_sum  = (edge_det && (edge_cnt != {CNT_W{1'b1}})) ? edge_cnt + 1'b1 : edge_cnt;
    assign bcd_next  = dd_step(bcd_sh, bin_sh[CNT_W-1]);
    assign over      = (LW'(conv_val) > LIMIT);

    // The window is open only while counting; reset and en=0 close it at once.
    assign gate = rst_n & en & (state == ST_GATE);

    // Synchronizer plus history flop for rising-edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_GATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: en=0 always parks the machine at the start of a window.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = ST_GATE;
        end else begin
            case (state)
                ST_GATE:    if (win_last) state_next = ST_CONVERT;
                ST_CONVERT: if (conv_last) state_next = ST_DONE;
                ST_DONE:    state_next = ST_GATE;
                default:    state_next = ST_GATE;
            endcase
        end
    end

    // Counting, conversion and result publication.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            conv_val <= '0;
            bin_sh   <= '0;
            bcd_sh   <= '0;
            conv_cnt <= '0;
            freq     <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
        end else if (!en) begin
            // Abort: drop any partial window or conversion, keep last results.
            win_cnt  <= '0;
            edge_cnt <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_GATE: begin
                    if (win_last) begin
                        // Final cycle's edge is included in the latched count.
                        conv_val <= edge_sum;
                        bin_sh   <= edge_sum;
                        bcd_sh   <= '0;
                        conv_cnt <= '0;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                    end else begin
                        win_cnt  <= win_cnt + 1'b1;
                        edge_cnt <= edge_sum;
                    end
                end
                ST_CONVERT: begin
                    bin_sh   <= bin_sh << 1;
                    bcd_sh   <= bcd_next;
                    conv_cnt <= conv_cnt + 1'b1;
                    if (conv_last) begin
                        valid <= 1'b1;
                        freq  <= conv_val;
                        ovf   <= over;
                        bcd   <= over ? {BCD_DIGITS{4'h9}} : bcd_next[4*BCD_DIGITS-1:0];
                    end
                end
                default: begin
                    // ST_DONE: results are on the outputs; window restarts next cycle.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysu_freq_meter.sv
// Bench for sysu_freq_meter with a short gate (1000 cycles). Three instances
// share stimulus: 8-digit display, 2-digit display (overflow path) and an
// 8-bit counter (saturation path).
module tb_sysu_freq_meter;

  localparam int GATE = 1000;
  localparam int MEAS = 1033;

  logic clk_in = 1'b0;
  logic rst_n;
  logic en;
  logic sig_in;

  logic [31:0] freq1;
  logic [31:0] bcd1;
  logic        ovf1, valid1, gate1;
  logic [31:0] freq2;
  logic [7:0]  bcd2;
  logic        ovf2, valid2, gate2;
  logic [7:0]  freq3;
  logic [11:0] bcd3;
  logic        ovf3, valid3, gate3;

  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  logic [31:0] exp_q3[$];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  sysu_freq_meter #(.CLK_HZ(GATE), .GATE_CYCLES(GATE), .CNT_W(32), .BCD_DIGITS(8)) dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(freq1), .bcd(bcd1), .ovf(ovf1), .valid(valid1), .gate(gate1)
  );

  sysu_freq_meter #(.CLK_HZ(GATE), .GATE_CYCLES(GATE), .CNT_W(32), .BCD_DIGITS(2)) dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(freq2), .bcd(bcd2), .ovf(ovf2), .valid(valid2), .gate(gate2)
  );

  sysu_freq_meter #(.CLK_HZ(GATE), .GATE_CYCLES(GATE), .CNT_W(8), .BCD_DIGITS(3)) dut3 (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(freq3), .bcd(bcd3), .ovf(ovf3), .valid(valid3), .gate(gate3)
  );

  // ---------------- reference model ----------------
  function automatic longint dec_max(input int digits);
    longint lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return lim - 1;
  endfunction

  function automatic logic [63:0] bcd_of(input longint f, input int digits);
    logic [63:0] r = '0;
    longint v = f;
    if (f > dec_max(digits)) begin
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'd9;
    end else begin
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- signal generator ----------------
  int per = 10;
  bit hold_hi = 1'b1;
  int ph = 0;

  always @(negedge clk_in) begin
    ph = (ph + 1) % per;
    sig_in = hold_hi ? 1'b1 : (ph < per / 2);
  end

  // ---------------- monitors ----------------
  int          en_cnt = 0;
  int          hi_run = 0;
  int          lo_run = 0;
  logic [31:0] freq_prev = '0;
  logic        valid_prev = 1'b0;

  always @(negedge clk_in) begin
    logic [31:0] f;
    if (!rst_n || !en) begin
      en_cnt = 0;
      hi_run = 0;
      lo_run = 0;
    end else begin
      en_cnt++;
      if (gate1) hi_run++;
      else lo_run++;
    end
    if (valid1) begin
      check("valid_single", valid_prev, 0);
      check("valid_timing", (en_cnt > 0) && (en_cnt % MEAS == 0), 1);
      check("gate_high_len", hi_run, GATE);
      check("gate_low_len", lo_run, MEAS - GATE);
      hi_run = 0;
      lo_run = 0;
      if (exp_q1.size() == 0) begin
        check("unexpected_valid1", 1, 0);
      end else begin
        f = exp_q1.pop_front();
        check("freq1", freq1, f);
        check("bcd1", bcd1, bcd_of(f, 8));
        check("ovf1", ovf1, f > dec_max(8));
      end
    end else if (rst_n) begin
      check("freq1_hold", freq1, freq_prev);
    end
    freq_prev = freq1;
    valid_prev = valid1;
  end

  always @(negedge clk_in) begin
    logic [31:0] f;
    if (valid2) begin
      if (exp_q2.size() == 0) begin
        check("unexpected_valid2", 1, 0);
      end else begin
        f = exp_q2.pop_front();
        check("freq2", freq2, f);
        check("bcd2", bcd2, bcd_of(f, 2));
        check("ovf2", ovf2, f > dec_max(2));
      end
    end
  end

  // The 8-bit instance is only scored in segments that queue results for it.
  always @(negedge clk_in) begin
    logic [31:0] f;
    if (valid3 && exp_q3.size() > 0) begin
      f = exp_q3.pop_front();
      check("freq3", freq3, f);
      check("bcd3", bcd3, bcd_of(f, 3));
      check("ovf3", ovf3, f > dec_max(3));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input int budget);
    int c = 0;
    while ((exp_q1.size() + exp_q2.size() + exp_q3.size()) != 0 && c < budget) begin
      @(posedge clk_in);
      c++;
    end
    if ((exp_q1.size() + exp_q2.size() + exp_q3.size()) != 0) begin
      check("drain_timeout", exp_q1.size() + exp_q2.size() + exp_q3.size(), 0);
      exp_q1.delete();
      exp_q2.delete();
      exp_q3.delete();
    end
  endtask

  task automatic push_exp(input int edges, input bit use3);
    exp_q1.push_back(32'(edges));
    exp_q2.push_back(32'(edges));
    if (use3) exp_q3.push_back((edges > 255) ? 32'd255 : 32'(edges));
  endtask

  // Change the waveform with en low, then run nwin full windows.
  task automatic run_seg(input int p, input int nwin, input bit use3);
    @(posedge clk_in); #1;
    en = 1'b0;
    per = p;
    hold_hi = 1'b0;
    repeat ($urandom_range(6, 20)) @(posedge clk_in);
    #1;
    for (int i = 0; i < nwin; i++) push_exp(GATE / p, use3);
    en = 1'b1;
    wait_drain(nwin * MEAS + 20);
  endtask

  task automatic abort_seg();
    @(posedge clk_in); #1;
    en = 1'b0;
    per = 4;
    repeat (8) @(posedge clk_in);
    #1;
    push_exp(GATE / 4, 1'b0);
    en = 1'b1;
    repeat (600) @(posedge clk_in);
    #1;
    en = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    check("abort_hold_freq", freq1, 500);
    check("abort_hold_bcd", bcd1, 32'h500);
    en = 1'b1;
    wait_drain(MEAS + 20);
  endtask

  task automatic reset_in_convert_seg();
    int c = 0;
    @(posedge clk_in); #1;
    en = 1'b0;
    per = 8;
    repeat (8) @(posedge clk_in);
    #1;
    en = 1'b1;
    while (gate1 && c < GATE + 100) begin
      @(posedge clk_in); #1;
      c++;
    end
    check("gate_fall_seen", gate1, 0);
    repeat (10) @(posedge clk_in);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_freq", freq1, 0);
    check("rst_mid_bcd", bcd1, 0);
    check("rst_mid_ovf", ovf1, 0);
    check("rst_mid_valid", valid1, 0);
    check("rst_mid_gate", gate1, 0);
    en = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    push_exp(GATE / 8, 1'b0);
    en = 1'b1;
    wait_drain(MEAS + 20);
  endtask

  // ---------------- main sequence ----------------
  int tbl[13] = '{2, 4, 5, 8, 10, 20, 25, 40, 50, 100, 125, 200, 250};

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    sig_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_freq", freq1, 0);
    check("reset_bcd", bcd1, 0);
    check("reset_ovf", ovf1, 0);
    check("reset_valid", valid1, 0);
    check("reset_gate", gate1, 0);

    // sig_in high through reset: one edge, then none.
    push_exp(1, 1'b0);
    push_exp(0, 1'b0);
    rst_n = 1'b1;
    wait_drain(2 * MEAS + 20);

    run_seg(10, 2, 1'b0);
    run_seg(2, 1, 1'b1);
    abort_seg();
    reset_in_convert_seg();

    for (int i = 0; i < 5; i++) begin
      run_seg(tbl[$urandom_range(0, 12)], $urandom_range(1, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sysu_freq_meter.md
Name: sysu_freq_meter

Overview:
- Measures the frequency of an external or divided-down signal against the board clock, producing both a binary edge count and a BCD result.
- Counts rising edges of `sig_in` over a fixed gate window of GATE_CYCLES clocks. With the default GATE_CYCLES = CLK_HZ, the window is 1 s and the result is in Hz.
- Converts the count to BCD with a sequential double-dabble for the seven-segment display path.
- Acts as the measuring end for slow clocks produced elsewhere in the design, and for front-panel inputs.

Parameters:
- CLK_HZ, 50000000, board clock frequency in Hz (documentation only; sets the default gate).
- GATE_CYCLES, 50000000, gate window length in clk_in cycles; must be ≥ 2.
- CNT_W, 32, width of the edge counter and the `freq` output.
- BCD_DIGITS, 8, number of BCD digits on `bcd`; 1..10.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable; low aborts and holds the block idle.
- sig_in  input  1  asynchronous signal to measure.
- freq  output  CNT_W  last completed edge count, saturating.
- bcd  output  4*BCD_DIGITS  BCD of `freq`; digit 0 in bits [3:0].
- ovf  output  1  `freq` exceeds 10^BCD_DIGITS-1; `bcd` forced to all 9s.
- valid  output  1  one-cycle pulse when `freq`, `bcd` and `ovf` update.
- gate  output  1  high while the gate window is open (LED drive).

Behaviour:
- Reset (rst_n=0, async): all registers cleared; freq=0, bcd=0, ovf=0, valid=0, gate=0; synchronizer flops=0; state=GATE with window count=0.
- Synchronizer:
  - 2-flop synchronizer s1→s2, plus a third flop s3.
  - An edge is the cycle where s2=1 and s3=0.
  - Latency from a `sig_in` rise to edge detect is 2–3 cycles.
  - Because the synchronizer resets to 0, `sig_in` held high through reset yields exactly one edge after release.
- State GATE (gate=1):
  - The window counter runs 0..GATE_CYCLES-1.
  - Every detected edge in GATE increments the edge counter, including the cycle where window count = GATE_CYCLES-1.
  - The edge counter saturates at 2^CNT_W-1 and never wraps.
  - On the cycle with window count = GATE_CYCLES-1, the final count (including that cycle's edge) is latched into a conversion register. The next state is CONVERT, and the window and edge counters clear.
- State CONVERT (gate=0):
  - Exactly CNT_W cycles of shift-add-3 double-dabble on the latched value.
  - Edges detected here are not counted. Dead time = CNT_W+1 cycles per measurement.
- State DONE (gate=0), 1 cycle:
  - valid=1.
  - freq ← latched value.
  - If value > 10^BCD_DIGITS-1: ovf=1 and bcd = all 9s. Otherwise ovf=0 and bcd = conversion result.
  - Next state is GATE with window count=0.
- Outputs `freq`, `bcd` and `ovf` hold their values between valid pulses. `valid` is never high two consecutive cycles.
- Measurement period = GATE_CYCLES + CNT_W + 1 cycles.
- en=0, any state:
  - Next cycle: state=GATE, window and edge counters=0, gate=0, valid=0.
  - freq, bcd and ovf hold their last values; synchronizer keeps running.
  - A conversion in progress is discarded with no valid.
  - The first cycle with en=1 is window count 0.
- Reset mid-operation clears everything immediately, regardless of state.
- Edge count when sig_in is periodic with period P ≥ 2 cycles and GATE_CYCLES a multiple of P: exactly GATE_CYCLES/P per window, independent of phase.

Test Plan (GATE_CYCLES=1000, CNT_W=32, BCD_DIGITS=8 unless stated):
- Square wave, period 10 cycles, from reset → first valid at cycle ≈1000+33; freq=100, bcd=0x00000100, ovf=0; repeats every 1033 cycles.
- sig_in held high from before reset release → first valid freq=1, bcd=0x00000001; second valid freq=0, bcd=0.
- Square wave, period 2 cycles → freq=500, bcd=0x00000500. Repeat with BCD_DIGITS=2 → freq=500, ovf=1, bcd=0x99.
- Period-4 square wave; deassert en for 5 cycles at window count 600; reassert → no valid during abort, prior freq/bcd held; next valid exactly 1000+33 cycles after en rises, freq=250.
- Square wave, period 8 cycles (125 edges); assert rst_n=0 during CONVERT → all outputs 0 immediately; after release, next valid freq=125, bcd=0x00000125.
- Check `gate` high exactly 1000 cycles and low 33 per period; `valid` is a single cycle and coincides with `freq` changing.
